led_indicator_scheduler: RTL and testbench

//  Shares the board's two indicator LEDs (LED_A, LED_B) between two requesters.

---
 rtl/led_indicator_scheduler.sv | 133 +++++++++++++
 tb/tb_led_indicator_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_indicator_scheduler.sv
// Shares two indicator LEDs between two requesters: prescaled tick, blink phase,
// round-robin ownership with a minimum hold time, and registered LED drive.
module led_indicator_scheduler #(
    parameter int PRESCALE    = 1000,
    parameter int BLINK_TICKS = 4,
    parameter int HOLD_TICKS  = 8
) (
    input  logic       CLK,
    input  logic       not_RST,
    input  logic [1:0] req,
    input  logic [1:0] mode0,
    input  logic [1:0] mode1,
    output logic [1:0] grant,
    output logic       tick,
    output logic       LED_A,
    output logic       LED_B
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    state_t        next_state;
    logic          last_served;
    logic          next_last;
    logic          reload;
    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [HW-1:0] hold;
    logic [1:0]    owner_mode;
    logic          next_a;
    logic          next_b;

    // Ownership decision; LEDs are decoded from the next owner so they move with grant.
    always_comb begin
        next_state = state;
        next_last  = last_served;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    reload = 1'b1;
                    if (last_served)
                        next_state = req[0] ? OWN0 : OWN1;
                    else
                        next_state = req[1] ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!req[0]) begin
                    next_last  = 1'b0;
                    next_state = req[1] ? OWN1 : IDLE;
                    reload     = req[1];
                end else if (hold == '0 && req[1]) begin
                    next_last  = 1'b0;
                    next_state = OWN1;
                    reload     = 1'b1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    next_last  = 1'b1;
                    next_state = req[0] ? OWN0 : IDLE;
                    reload     = req[0];
                end else if (hold == '0 && req[0]) begin
                    next_last  = 1'b1;
                    next_state = OWN0;
                    reload     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase

        owner_mode = (next_state == OWN1) ? mode1 : mode0;
        next_a     = 1'b0;
        next_b     = 1'b0;
        if (next_state != IDLE) begin
            case (owner_mode)
                2'd1: begin next_a = 1'b1;  next_b = 1'b1;   end
                2'd2: begin next_a = phase; next_b = phase;  end
                2'd3: begin next_a = phase; next_b = ~phase; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!not_RST) begin
            pre_cnt     <= '0;
            tick        <= 1'b0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            hold        <= '0;
            state       <= IDLE;
            last_served <= 1'b1;
            grant       <= 2'b00;
            LED_A       <= 1'b0;
            LED_B       <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;

            if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // A reload on a new grant swallows any coincident tick.
            if (reload)
                hold <= HOLD_LOAD;
            else if (state != IDLE && tick && hold != '0)
                hold <= hold - 1'b1;

            state       <= next_state;
            last_served <= next_last;
            grant       <= {next_state == OWN1, next_state == OWN0};
            LED_A       <= next_a;
            LED_B       <= next_b;
        end
    end

endmodule

// File: tb/tb_led_indicator_scheduler.sv
// Self-checking bench for led_indicator_scheduler: vector table through a
// scoreboard queue, then hand-written multi-cycle sequences.
module tb_led_indicator_scheduler;

    localparam int PRESCALE    = 4;
    localparam int BLINK_TICKS = 2;
    localparam int HOLD_TICKS  = 8;

    logic       CLK = 1'b0;
    logic       not_RST = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] mode0 = 2'b00;
    logic [1:0] mode1 = 2'b00;
    logic [1:0] grant;
    logic       tick;
    logic       LED_A;
    logic       LED_B;

    led_indicator_scheduler #(
        .PRESCALE(PRESCALE),
        .BLINK_TICKS(BLINK_TICKS),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .CLK(CLK),
        .not_RST(not_RST),
        .req(req),
        .mode0(mode0),
        .mode1(mode1),
        .grant(grant),
        .tick(tick),
        .LED_A(LED_A),
        .LED_B(LED_B)
    );

    always #5 CLK = ~CLK;

    // expected packs {grant, tick, LED_A, LED_B}
    typedef struct {
        logic [1:0] req;
        logic [1:0] mode0;
        logic [1:0] mode1;
        logic [4:0] expected;
    } vec_t;

    vec_t       vecs[9];
    logic [4:0] sb_queue[$];
    int         total = 0;
    int         passed = 0;

    function automatic logic [4:0] observed();
        return {grant, tick, LED_A, LED_B};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input vec_t v);
        req   = v.req;
        mode0 = v.mode0;
        mode1 = v.mode1;
        sb_queue.push_back(v.expected);
    endtask

    task automatic checkOutput(input string name);
        logic [4:0] e;
        if (sb_queue.size() == 0) begin
            total++;
            $display("[TB] FAIL %s: got empty scoreboard, required one entry", name);
        end else begin
            e = sb_queue.pop_front();
            check(name, observed(), e);
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        not_RST = 1'b0;
        req     = 2'b00;
        mode0   = 2'b00;
        mode1   = 2'b00;
        repeat (2) step();
        check("reset state", observed(), 5'b00000);
        not_RST = 1'b1;
    endtask

    initial begin
        int   cyc;
        int   start;
        int   seen_ticks;
        int   toggles;
        int   last_change;
        logic prev_a;
        vec_t v;

        vecs[0] = '{2'b00, 2'd1, 2'd0, 5'b00000};
        vecs[1] = '{2'b01, 2'd1, 2'd0, 5'b01011};
        vecs[2] = '{2'b01, 2'd0, 2'd0, 5'b01000};
        vecs[3] = '{2'b11, 2'd3, 2'd1, 5'b01101};
        vecs[4] = '{2'b10, 2'd3, 2'd1, 5'b10011};
        vecs[5] = '{2'b10, 2'd3, 2'd2, 5'b10000};
        vecs[6] = '{2'b00, 2'd3, 2'd2, 5'b00000};
        vecs[7] = '{2'b11, 2'd3, 2'd2, 5'b01101};
        vecs[8] = '{2'b11, 2'd1, 2'd2, 5'b01011};

        // Idle prescaler: tick every PRESCALE cycles, nothing else moves.
        doReset();
        for (int c = 1; c <= 20; c++) begin
            v = '{2'b00, 2'd1, 2'd1, {2'b00, (c % PRESCALE) == 0, 2'b00}};
            applyStimulus(v);
            step();
            checkOutput($sformatf("idle cycle %0d", c));
        end

        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vector %0d", i));
        end

        // Blink owned by requester 0: half-period 8 cycles, A tracks B.
        doReset();
        req = 2'b01;
        mode0 = 2'd2;
        step();
        check("blink grant", observed(), 5'b01000);
        toggles = 0;
        last_change = -1;
        prev_a = LED_A;
        for (int c = 2; c <= 100 && toggles < 3; c++) begin
            step();
            if (LED_A !== prev_a) begin
                toggles++;
                check("blink a equals b", {4'b0, LED_A}, {4'b0, LED_B});
                if (last_change >= 0)
                    check("blink interval", 5'(c - last_change), 5'd8);
                last_change = c;
                prev_a = LED_A;
            end
        end
        check("blink toggle count", 5'(toggles), 5'd3);

        // Round-robin with both requesting: hold of 8 ticks each way.
        doReset();
        req = 2'b11;
        mode0 = 2'd1;
        mode1 = 2'd1;
        step();
        check("rr first grant", observed(), 5'b01011);
        cyc = 1;
        seen_ticks = 0;
        while (grant == 2'b01 && cyc < 200) begin
            if (tick) seen_ticks++;
            step();
            cyc++;
        end
        check("rr owner0 cycles", 5'(cyc - 1), 5'd33);
        check("rr owner0 ticks", 5'(seen_ticks), 5'd8);
        check("rr handover to 1", {3'b0, grant}, 5'b00010);
        start = cyc;
        seen_ticks = 0;
        while (grant == 2'b10 && cyc < 400) begin
            if (tick) seen_ticks++;
            step();
            cyc++;
        end
        check("rr owner1 cycles", 5'(cyc - start), 5'd32);
        check("rr owner1 ticks", 5'(seen_ticks), 5'd8);
        check("rr handover to 0", {3'b0, grant}, 5'b00001);

        // Owner 0 drops request mid-hold: direct 01 -> 10.
        doReset();
        req = 2'b11;
        mode0 = 2'd1;
        mode1 = 2'd3;
        repeat (13) step();
        check("drop before", {3'b0, grant}, 5'b00001);
        req = 2'b10;
        step();
        check("drop handover", {3'b0, grant}, 5'b00010);

        toggles = 0;
        prev_a = LED_A;
        for (int c = 0; c < 20; c++) begin
            check("alternate complement", {4'b0, LED_A}, {4'b0, ~LED_B});
            if (LED_A !== prev_a) toggles++;
            prev_a = LED_A;
            step();
        end
        check("alternate toggled", {4'b0, toggles > 0}, 5'b00001);
        mode1 = 2'd1;
        step();
        check("solid after alternate", {3'b0, LED_A, LED_B}, 5'b00011);

        // Reset while owning with LEDs lit, then requester 0 wins again.
        not_RST = 1'b0;
        step();
        check("reset mid-own", observed(), 5'b00000);
        not_RST = 1'b1;
        req = 2'b11;
        step();
        check("post-reset grant", {3'b0, grant}, 5'b00001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
